// File: rtl/trace_ring_repository_if.sv
// trace_ring_repository_if: capture, dispatch, completion, status, lookup and count bundle
interface trace_ring_repository_if #(
  parameter int DEPTH = 2048,
  parameter int ENTRY_W = 64,
  parameter int ADDR_W = 16
);
  localparam int IW = $clog2(DEPTH);
  logic cap_valid, cap_ready, lock;
  logic [ENTRY_W-1:0] cap_data;
  logic [ADDR_W-1:0] cap_addr;
  logic req, cancel;
  logic out_valid, out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [IW-1:0] out_index;
  logic cancelled, drained;
  logic done_valid, done_requeue, done_ack;
  logic [IW-1:0] done_index;
  logic [IW-1:0] status_index;
  logic status_retired;
  logic lookup_req, lookup_valid, lookup_miss;
  logic [ADDR_W-1:0] lookup_addr;
  logic [IW-1:0] lookup_index;
  logic [IW:0] count;
  modport slave (
    input cap_valid, cap_data, cap_addr, lock, req, cancel, out_ready,
          done_valid, done_index, done_requeue, status_index, lookup_req, lookup_addr,
    output cap_ready, out_valid, out_data, out_addr, out_index, cancelled, drained,
           done_ack, status_retired, lookup_valid, lookup_miss, lookup_index, count
  );
  modport master (
    output cap_valid, cap_data, cap_addr, lock, req, cancel, out_ready,
           done_valid, done_index, done_requeue, status_index, lookup_req, lookup_addr,
    input cap_ready, out_valid, out_data, out_addr, out_index, cancelled, drained,
          done_ack, status_retired, lookup_valid, lookup_miss, lookup_index, count
  );
endinterface

// File: rtl/trace_ring_repository.sv
// trace_ring_repository: circular trace store with in-order, address-hazard-aware dispatch
// Ports: clk (rising edge), rst (synchronous, active-high), bus (slave modport): capture
// (cap_*, lock), dispatch (req, cancel, out_*, cancelled, drained), completion (done_*),
// status query (status_*), address lookup (lookup_*) and occupancy (count).
// Build option: define TRACE_REPO_LOOKUP_EN to build the lookup port; otherwise it reads 0.
// All outputs are forced to 0 while rst is high.
module trace_ring_repository #(
  parameter int DEPTH = 2048,
  parameter int ENTRY_W = 64,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  trace_ring_repository_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {FREE, PENDING, ISSUED, RETIRED} slot_t;
  typedef enum logic [1:0] {IDLE, SCAN, OFFER} fsm_t;
  slot_t st [DEPTH];
  logic [ENTRY_W-1:0] data_m [DEPTH];
  logic [ADDR_W-1:0] addr_m [DEPTH];
  logic [IW-1:0] head, tail, sel, oi;
  logic [CW-1:0] cnt, sel_off;
  logic [ENTRY_W+ADDR_W-1:0] last;
  logic last_v, rdy, cap, frees, found, hazard;
  fsm_t fsm;
  logic ov, canc, drn, dack;
  logic [ENTRY_W-1:0] od;
  logic [ADDR_W-1:0] oa;
  assign rdy = !bus.lock && cnt != CW'(DEPTH);
  assign cap = bus.cap_valid && rdy && !(last_v && {bus.cap_data, bus.cap_addr} == last);
  assign frees = st[head] == RETIRED && cnt != '0;
  always_comb begin
    found = 1'b0;
    sel = head;
    sel_off = '0;
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (!found && CW'(i) < cnt && st[head + IW'(i)] == PENDING) begin
        found = 1'b1;
        sel = head + IW'(i);
        sel_off = CW'(i);
      end
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < sel_off && (st[head + IW'(i)] == ISSUED || st[head + IW'(i)] == PENDING) &&
          addr_m[head + IW'(i)] == addr_m[sel])
        hazard = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      last <= '0;
      last_v <= 1'b0;
      fsm <= IDLE;
      ov <= 1'b0;
      canc <= 1'b0;
      drn <= 1'b0;
      dack <= 1'b0;
      od <= '0;
      oa <= '0;
      oi <= '0;
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
    end else begin
      canc <= 1'b0;
      drn <= 1'b0;
      dack <= bus.done_valid;
      cnt <= cnt + CW'(cap) - CW'(frees);
      if (frees) begin
        st[head] <= FREE;
        head <= head + 1'b1;
      end
      if (cap) begin
        st[tail] <= PENDING;
        data_m[tail] <= bus.cap_data;
        addr_m[tail] <= bus.cap_addr;
        tail <= tail + 1'b1;
        last <= {bus.cap_data, bus.cap_addr};
        last_v <= 1'b1;
      end
      if (bus.done_valid && st[bus.done_index] == ISSUED)
        st[bus.done_index] <= bus.done_requeue ? PENDING : RETIRED;
      case (fsm)
        IDLE: if (bus.req) fsm <= SCAN;
        SCAN:
          if (bus.cancel) begin
            canc <= 1'b1;
            fsm <= IDLE;
          end else if (!found) begin
            drn <= 1'b1;
            fsm <= IDLE;
          end else if (!hazard) begin
            ov <= 1'b1;
            od <= data_m[sel];
            oa <= addr_m[sel];
            oi <= sel;
            st[sel] <= ISSUED;
            fsm <= OFFER;
          end
        OFFER:
          if (bus.out_ready) begin
            ov <= 1'b0;
            fsm <= IDLE;
          end
        default: fsm <= IDLE;
      endcase
    end
  end
  assign bus.cap_ready = !rst && rdy;
  assign bus.out_valid = !rst && ov;
  assign bus.out_data = rst ? '0 : od;
  assign bus.out_addr = rst ? '0 : oa;
  assign bus.out_index = rst ? '0 : oi;
  assign bus.cancelled = !rst && canc;
  assign bus.drained = !rst && drn;
  assign bus.done_ack = !rst && dack;
  assign bus.count = rst ? '0 : cnt;
  assign bus.status_retired = !rst && (st[bus.status_index] == RETIRED || st[bus.status_index] == FREE);
`ifdef TRACE_REPO_LOOKUP_EN
  logic lk_hit, lv, lm;
  logic [IW-1:0] lk_idx, li;
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!lk_hit && CW'(i) < cnt && st[head + IW'(i)] != RETIRED && st[head + IW'(i)] != FREE &&
          addr_m[head + IW'(i)] == bus.lookup_addr) begin
        lk_hit = 1'b1;
        lk_idx = head + IW'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lv <= 1'b0;
      lm <= 1'b0;
      li <= '0;
    end else begin
      lv <= bus.lookup_req && lk_hit;
      lm <= bus.lookup_req && !lk_hit;
      li <= lk_idx;
    end
  end
  assign bus.lookup_valid = !rst && lv;
  assign bus.lookup_miss = !rst && lm;
  assign bus.lookup_index = rst ? '0 : li;
`else
  logic unused_lookup;
  assign unused_lookup = ^{bus.lookup_req, bus.lookup_addr};
  assign bus.lookup_valid = 1'b0;
  assign bus.lookup_miss = 1'b0;
  assign bus.lookup_index = '0;
`endif
endmodule

// File: tb/tb_trace_ring_repository.sv
// tb_trace_ring_repository: directed and randomized checks against a queue-based reference model
module tb_trace_ring_repository;
  localparam int DEPTH = 4;
  localparam int ENTRY_W = 16;
  localparam int ADDR_W = 8;
  localparam int IW = $clog2(DEPTH);
  localparam int S_PEND = 1;
  localparam int S_ISS = 2;
  localparam int S_RET = 3;
  typedef struct {
    logic [ENTRY_W-1:0] d;
    logic [ADDR_W-1:0] a;
    int st;
    int slot;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ent_t q[$];
  int next_slot = 0;
  int passed = 0;
  int total = 0;
  logic [ENTRY_W+ADDR_W-1:0] last = '0;
  logic last_v = 1'b0;
  always #5 clk = ~clk;
  trace_ring_repository_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W)) bus ();
  trace_ring_repository #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int mstate(input int s);
    foreach (q[i]) if (q[i].slot == s) return q[i].st;
    return 0;
  endfunction
  task automatic settle();
    repeat (DEPTH + 1) tick();
    while (q.size() > 0 && q[0].st == S_RET) void'(q.pop_front());
    chk("count", bus.count, q.size());
    for (int s = 0; s < DEPTH; s++) begin
      bus.status_index = IW'(s);
      #1 chk("status_retired", bus.status_retired, mstate(s) == 0 || mstate(s) == S_RET);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_cap_ready", bus.cap_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    tick();
    tick();
    chk("rst_out_valid_q", bus.out_valid, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_cap_ready_q", bus.cap_ready, 1'b0);
    chk("rst_status", bus.status_retired, 1'b0);
    chk("rst_cancelled", bus.cancelled, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_cap_ready", bus.cap_ready, 1'b1);
    chk("rel_count", bus.count, 0);
    q.delete();
    next_slot = 0;
    last = '0;
    last_v = 1'b0;
    tick();
    chk("rel_cancelled", bus.cancelled, 1'b0);
    chk("rel_out_valid", bus.out_valid, 1'b0);
  endtask
  task automatic do_capture(input logic [ENTRY_W-1:0] d, input logic [ADDR_W-1:0] a, input bit lk);
    bit rdy;
    rdy = !lk && q.size() < DEPTH;
    bus.lock = lk;
    bus.cap_valid = 1'b1;
    bus.cap_data = d;
    bus.cap_addr = a;
    #1 chk("cap_ready", bus.cap_ready, rdy);
    tick();
    bus.cap_valid = 1'b0;
    bus.lock = 1'b0;
    if (rdy && !(last_v && {d, a} == last)) begin
      q.push_back('{d, a, S_PEND, next_slot});
      next_slot = (next_slot + 1) % DEPTH;
      last = {d, a};
      last_v = 1'b1;
    end
    settle();
  endtask
  task automatic do_dispatch(input int hold, input bit cx);
    int p;
    bit haz;
    p = -1;
    haz = 1'b0;
    foreach (q[i]) if (p < 0 && q[i].st == S_PEND) p = i;
    for (int i = 0; i < p; i++)
      if ((q[i].st == S_ISS || q[i].st == S_PEND) && q[i].a == q[p].a) haz = 1'b1;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    chk("scan_out_valid", bus.out_valid, 1'b0);
    if (p >= 0 && (haz || cx)) begin
      repeat (haz ? 3 : 0) begin
        tick();
        chk("blocked_out_valid", bus.out_valid, 1'b0);
      end
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      chk("cancelled", bus.cancelled, 1'b1);
      chk("cancel_out_valid", bus.out_valid, 1'b0);
      tick();
      chk("cancelled_pulse", bus.cancelled, 1'b0);
    end else if (p < 0) begin
      tick();
      chk("drained", bus.drained, 1'b1);
      chk("drained_out_valid", bus.out_valid, 1'b0);
      tick();
      chk("drained_pulse", bus.drained, 1'b0);
    end else begin
      tick();
      for (int h = 0; h <= hold; h++) begin
        if (h > 0) tick();
        chk("out_valid", bus.out_valid, 1'b1);
        chk("out_index", bus.out_index, q[p].slot);
        chk("out_data", bus.out_data, q[p].d);
        chk("out_addr", bus.out_addr, q[p].a);
        bus.cancel = h < hold;
        bus.out_ready = h == hold;
      end
      tick();
      bus.cancel = 1'b0;
      bus.out_ready = 1'b0;
      chk("accept_out_valid", bus.out_valid, 1'b0);
      chk("offer_no_cancel", bus.cancelled, 1'b0);
      q[p].st = S_ISS;
    end
    settle();
  endtask
  task automatic do_done(input int idx, input bit rq);
    int pos = -1;
    foreach (q[i]) if (q[i].slot == idx) pos = i;
    bus.done_valid = 1'b1;
    bus.done_index = IW'(idx);
    bus.done_requeue = rq;
    tick();
    bus.done_valid = 1'b0;
    chk("done_ack", bus.done_ack, 1'b1);
    tick();
    chk("done_ack_pulse", bus.done_ack, 1'b0);
    if (pos >= 0 && q[pos].st == S_ISS) q[pos].st = rq ? S_PEND : S_RET;
    settle();
  endtask
  task automatic do_lookup(input logic [ADDR_W-1:0] a);
    int pos = -1;
    foreach (q[i]) if (pos < 0 && q[i].st != S_RET && q[i].a == a) pos = i;
    bus.lookup_req = 1'b1;
    bus.lookup_addr = a;
    tick();
    bus.lookup_req = 1'b0;
`ifdef TRACE_REPO_LOOKUP_EN
    chk("lookup_valid", bus.lookup_valid, pos >= 0);
    chk("lookup_miss", bus.lookup_miss, pos < 0);
    if (pos >= 0) chk("lookup_index", bus.lookup_index, q[pos].slot);
`else
    chk("lookup_valid_tied", bus.lookup_valid, 1'b0);
    chk("lookup_miss_tied", bus.lookup_miss, 1'b0);
    chk("lookup_index_tied", bus.lookup_index, 0);
`endif
    tick();
    chk("lookup_pulse", bus.lookup_valid, 1'b0);
  endtask
  initial begin
    bus.cap_valid = 1'b0;
    bus.cap_data = '0;
    bus.cap_addr = '0;
    bus.lock = 1'b0;
    bus.req = 1'b0;
    bus.cancel = 1'b0;
    bus.out_ready = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_index = '0;
    bus.done_requeue = 1'b0;
    bus.status_index = '0;
    bus.lookup_req = 1'b0;
    bus.lookup_addr = '0;
    do_reset();
    do_capture(16'h1111, 8'h10, 1'b0);
    do_capture(16'h2222, 8'h10, 1'b0);
    do_dispatch(0, 1'b0);
    do_dispatch(0, 1'b0);
    do_done(0, 1'b1);
    do_dispatch(3, 1'b0);
    do_done(0, 1'b0);
    do_dispatch(0, 1'b0);
    do_done(1, 1'b0);
    do_capture(16'h00a0, 8'h10, 1'b0);
    do_capture(16'h00a0, 8'h10, 1'b0);
    do_dispatch(0, 1'b0);
    do_done(2, 1'b0);
    do_dispatch(0, 1'b0);
    do_lookup(8'h10);
    do_capture(16'h3333, 8'h20, 1'b0);
    do_dispatch(0, 1'b1);
    do_dispatch(0, 1'b0);
    do_lookup(8'h20);
    do_done(3, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) do_capture(16'(16'h4000 + k), 8'(8'h30 + k), 1'b0);
    do_capture(16'h4004, 8'h34, 1'b0);
    do_dispatch(0, 1'b0);
    do_done(0, 1'b0);
    do_capture(16'h4004, 8'h34, 1'b0);
    repeat (4) do_dispatch(0, 1'b0);
    do_capture(16'h5000, 8'h50, 1'b1);
    do_reset();
    do_capture(16'h6000, 8'h60, 1'b0);
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    chk("offer_before_rst", bus.out_valid, 1'b1);
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4)
        do_capture(16'($urandom_range(1, 3)), 8'(16 * $urandom_range(1, 3)), $urandom_range(0, 7) == 0);
      else if (op < 7)
        do_dispatch($urandom_range(0, 2), $urandom_range(0, 5) == 0);
      else if (op < 9)
        do_done($urandom_range(0, DEPTH - 1), $urandom_range(0, 1) == 1);
      else
        do_lookup(8'(16 * $urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trace_ring_repository.md
TRACE_RING_REPOSITORY -- requirements
Module: trace_ring_repository

Interface
REQ-001 Parameter DEPTH, default 2048, number of entry slots; power of two, at least 4; IW = $clog2(DEPTH).
REQ-002 Parameter ENTRY_W, default 64, trace payload width in bits.
REQ-003 Parameter ADDR_W, default 16, memory-address field width in bits.
REQ-004 Ports: clk  in  1  sole clock, all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cap_valid  in  1 / cap_data  in  ENTRY_W / cap_addr  in  ADDR_W  capture request.
REQ-007 cap_ready  out  1  capture slot available; lock  in  1  blocks capture.
REQ-008 req  in  1 / cancel  in  1  dispatch request and abort.
REQ-009 out_valid  out  1 / out_ready  in  1 / out_data  out  ENTRY_W / out_addr  out  ADDR_W / out_index  out  IW  dispatched entry.
REQ-010 cancelled  out  1 / drained  out  1  abort ack and no-pending-work ack.
REQ-011 done_valid  in  1 / done_index  in  IW / done_requeue  in  1 / done_ack  out  1  completion port.
REQ-012 status_index  in  IW / status_retired  out  1  combinational state query.
REQ-013 lookup_req  in  1 / lookup_addr  in  ADDR_W / lookup_valid  out  1 / lookup_miss  out  1 / lookup_index  out  IW  address search.
REQ-014 count  out  IW+1  occupied slots.

Function
REQ-015 Storage is a circular buffer with head (oldest) and tail (next write) pointers; both wrap modulo DEPTH.
REQ-016 Each slot holds state FREE, PENDING, ISSUED or RETIRED.
REQ-017 cap_ready = !lock && count < DEPTH, registered-state derived; it does not see same-cycle frees.
REQ-018 A capture happens when cap_valid && cap_ready and {cap_data,cap_addr} differs from the last captured pair; the slot becomes PENDING and tail increments.
REQ-019 A duplicate of the last captured pair is dropped silently; the last-captured register persists until reset.
REQ-020 Each cycle, if the head slot is RETIRED and count>0, it becomes FREE and head increments; at most one free per cycle.
REQ-021 count changes by +1 on capture and -1 on free; both in the same cycle leave it unchanged.
REQ-022 The dispatch FSM has states IDLE, SCAN, OFFER.
REQ-023 IDLE: on req go to SCAN.
REQ-024 SCAN selects the oldest PENDING slot from head.
REQ-025 SCAN, no PENDING slot: pulse drained for 1 cycle, then IDLE.
REQ-026 SCAN hazard: an older ISSUED or PENDING slot with equal addr blocks dispatch; stay in SCAN, re-evaluating every cycle.
REQ-027 SCAN, cancel high while blocked or searching: pulse cancelled for 1 cycle, then IDLE; cancel wins over a same-cycle selection.
REQ-028 SCAN with a dispatchable slot: drive out_* registered, out_valid=1, slot becomes ISSUED, then OFFER.
REQ-029 OFFER holds out_* stable until out_ready, then out_valid=0 and IDLE; cancel is ignored in OFFER.
REQ-030 Latency from req to out_valid, unblocked: 2 cycles.
REQ-031 done_valid on an ISSUED slot: RETIRED if done_requeue=0, PENDING if done_requeue=1; done_ack pulses the next cycle.
REQ-032 done_valid on a non-ISSUED slot: no state change, done_ack still pulses.
REQ-033 status_retired = (state[status_index] == RETIRED || state[status_index] == FREE).
REQ-034 Lookup: one cycle after lookup_req, lookup_valid=1 with lookup_index = the oldest non-RETIRED occupied slot whose addr equals lookup_addr.
REQ-035 Lookup with no match: lookup_miss=1 and lookup_valid=0.

Reset
REQ-036 rst sets head=tail=0, count=0, all slots FREE, FSM IDLE, last-captured register cleared.
REQ-037 While rst is high, all outputs are 0 except cap_ready; cap_ready is 0 in the reset cycle.
REQ-038 rst mid-OFFER drops the offer without a cancelled pulse.

Configuration
REQ-039 Macro TRACE_REPO_LOOKUP_EN defined: the lookup port and its comparator array are built.
REQ-040 Macro undefined: lookup_valid, lookup_miss and lookup_index are tied to 0 and lookup_req is ignored.

Verification
REQ-041 DEPTH=4: capture 4 distinct entries, then a 5th -> cap_ready=0 and count=4; retire slot 0 -> head=1, then the 5th captures into slot 0 (wrap).
REQ-042 Capture A(addr 0x10) then A again -> count=1, duplicate dropped.
REQ-043 Capture X(0x10), Y(0x10); req twice without done -> X on index 0; second req blocks, cancel -> cancelled pulse, no out_valid.
REQ-044 Dispatch X, hold out_ready=0 for 3 cycles -> out_* stable; done_index=0 with requeue=1 -> X redispatched on next req.
REQ-045 All slots RETIRED, req -> drained pulses 1 cycle after SCAN; lookup 0x10 -> lookup_miss=1.
REQ-046 Assert rst during OFFER -> next cycle out_valid=0, count=0, cap_ready returns to 1 after release.
